// File: rtl/fxp_alu_pkg.sv
// Shared opcodes and fixed-point helpers for the pipelined ALU.
// Helpers work on 64-bit signed values with an explicit width.
package fxp_alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_ACC = 3;
  localparam int OP_MAC = 4;
  localparam int OP_CLR = 5;
  localparam int OP_XOR = 6;
  localparam int OP_ARS = 7;
  localparam int OP_CLZ = 8;
  localparam int OP_MAX = 9;
  localparam int OP_MIN = 10;

  function automatic logic signed [63:0] pos_max(
    input int w
  );
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] neg_max(
    input int w
  );
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] sat_val(
    input logic signed [63:0] v,
    input int w
  );
    if (v > pos_max(w)) return pos_max(w);
    if (v < neg_max(w)) return neg_max(w);
    return v;
  endfunction

  function automatic logic is_sat(
    input logic signed [63:0] v,
    input int w
  );
    return (v > pos_max(w)) || (v < neg_max(w));
  endfunction

  // round half up, then drop f fraction bits
  function automatic logic signed [63:0] round_shift(
    input logic signed [63:0] v,
    input int f
  );
    return (v + (64'sd1 <<< (f - 1))) >>> f;
  endfunction

endpackage

// File: rtl/fxp_acc_bank.sv
// Accumulator register file: async reset,
// one combinational read port, one write port.
module fxp_acc_bank #(
  parameter int DEPTH = 16,
  parameter int W     = 21,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [IW-1:0] i_rd_idx,
  output logic [W-1:0]  o_rd_data,
  input  logic          i_we,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [W-1:0]  i_wr_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // next contents: single-entry update on write enable
  always_comb begin
    mem_d = mem_q;
    if (i_we) mem_d[i_wr_idx] = i_wr_data;
  end

  // storage, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign o_rd_data = mem_q[i_rd_idx];

endmodule

// File: rtl/fxp_alu_pipe.sv
// Two-stage fixed-point ALU with accumulator bank,
// valid/ready in and out, single global advance.
module fxp_alu_pipe
  import fxp_alu_pkg::*;
#(
  parameter int INST_W    = 4,
  parameter int INT_W     = 6,
  parameter int FRAC_W    = 10,
  parameter int DATA_W    = INT_W + FRAC_W,
  parameter int ACC_DEPTH = 16,
  parameter int ACC_GUARD = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [INST_W-1:0] i_inst,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sat
);

  localparam int ACC_W = DATA_W + ACC_GUARD;
  localparam int IDX_W = $clog2(ACC_DEPTH);

  logic              adv;
  logic              v1_q, v1_d;
  logic [INST_W-1:0] inst1_q, inst1_d;
  logic [DATA_W-1:0] a1_q, a1_d;
  logic [DATA_W-1:0] b1_q, b1_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sat_q, sat_d;

  logic signed [63:0]       a64, b64, v64;
  logic                     use_sat;
  logic [DATA_W-1:0]        raw, res;
  logic                     res_sat;
  logic [IDX_W-1:0]         acc_idx;
  logic [ACC_W-1:0]         acc_rd;
  logic signed [ACC_W-1:0]  acc_new;
  logic                     acc_we;
  int                       clz;

  assign adv         = !ov_q | i_out_ready;
  assign o_in_ready  = adv;
  assign o_out_valid = ov_q;
  assign o_data      = data_q;
  assign o_sat       = sat_q;

  fxp_acc_bank #(
    .DEPTH (ACC_DEPTH),
    .W     (ACC_W)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd_idx  (acc_idx),
    .o_rd_data (acc_rd),
    .i_we      (acc_we & adv),
    .i_wr_idx  (acc_idx),
    .i_wr_data (acc_new)
  );

  // S2 arithmetic: result, clamp flag, accumulator update
  always_comb begin
    a64     = 64'($signed(a1_q));
    b64     = 64'($signed(b1_q));
    v64     = '0;
    use_sat = 1'b0;
    raw     = '0;
    acc_idx = a1_q[IDX_W-1:0];
    acc_new = '0;
    acc_we  = 1'b0;
    clz     = DATA_W;
    for (int i = 0; i < DATA_W; i++)
      if (a1_q[i]) clz = DATA_W - 1 - i;
    case (inst1_q)
      INST_W'(OP_ADD): begin
        v64     = a64 + b64;
        use_sat = 1'b1;
      end
      INST_W'(OP_SUB): begin
        v64     = a64 - b64;
        use_sat = 1'b1;
      end
      INST_W'(OP_MUL): begin
        v64     = round_shift(a64 * b64, FRAC_W);
        use_sat = 1'b1;
      end
      INST_W'(OP_ACC): begin
        acc_new = acc_rd + ACC_W'(b64);
        acc_we  = v1_q;
        v64     = 64'(acc_new);
        use_sat = 1'b1;
      end
      INST_W'(OP_MAC): begin
        acc_idx = b1_q[IDX_W-1:0];
        acc_new = acc_rd
                + ACC_W'(round_shift(a64 * b64, FRAC_W));
        acc_we  = v1_q;
        v64     = 64'(acc_new);
        use_sat = 1'b1;
      end
      INST_W'(OP_CLR): begin
        acc_new = '0;
        acc_we  = v1_q;
        v64     = 64'($signed(acc_rd));
        use_sat = 1'b1;
      end
      INST_W'(OP_XOR): raw = a1_q ^ b1_q;
      INST_W'(OP_ARS):
        raw = DATA_W'($signed(a1_q) >>> b1_q[3:0]);
      INST_W'(OP_CLZ): raw = DATA_W'(clz);
      INST_W'(OP_MAX):
        raw = ($signed(a1_q) > $signed(b1_q)) ? a1_q : b1_q;
      INST_W'(OP_MIN):
        raw = ($signed(a1_q) < $signed(b1_q)) ? a1_q : b1_q;
      default: ;
    endcase
    res     = use_sat ? DATA_W'(sat_val(v64, DATA_W)) : raw;
    res_sat = use_sat & is_sat(v64, DATA_W);
  end

  // both stages advance together or hold together
  always_comb begin
    v1_d    = v1_q;
    inst1_d = inst1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    ov_d    = ov_q;
    data_d  = data_q;
    sat_d   = sat_q;
    if (adv) begin
      v1_d    = i_in_valid;
      inst1_d = i_inst;
      a1_d    = i_data_a;
      b1_d    = i_data_b;
      ov_d    = v1_q;
      data_d  = res;
      sat_d   = res_sat;
    end
  end

  // pipeline registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q    <= 1'b0;
      inst1_q <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      ov_q    <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      inst1_q <= inst1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      ov_q    <= ov_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_fxp_alu_pipe.sv
// Directed bench for fxp_alu_pipe: vector table,
// accumulator stream, backpressure, MAC and reset.
module tb_fxp_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  inst;
  logic [15:0] da, db;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        sat;

  int total = 0;
  int bad   = 0;
  bit bp_en = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        s;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        s;
  } exp_t;

  vec_t vt[17];
  exp_t eq[$];

  fxp_alu_pipe dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_inst      (inst),
    .i_data_a    (da),
    .i_data_b    (db),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_data      (dout),
    .o_sat       (sat)
  );

  always #5 clk = ~clk;

  // output ready: constant 1, or pattern 1,0,0,1
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? pat[3 - (k % 4)] : 1'b1;
      k++;
    end
  end

  // output monitor / scoreboard
  bit          held = 0;
  logic [15:0] held_d;
  logic        held_s;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 0;
    end else begin
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("FAIL in_ready got=%b want=%b",
                 in_ready, !out_valid || out_ready);
      end
      if (held && out_valid) begin
        total++;
        if (dout !== held_d || sat !== held_s) begin
          bad++;
          $display("FAIL stall_hold got=%h/%b want=%h/%b",
                   dout, sat, held_d, held_s);
        end
      end
      held   = out_valid && !out_ready;
      held_d = dout;
      held_s = sat;
      if (out_valid && out_ready) begin
        total++;
        if (eq.size() == 0) begin
          bad++;
          $display("FAIL extra_result got=%h/%b want=none",
                   dout, sat);
        end else begin
          e = eq.pop_front();
          if (dout !== e.d || sat !== e.s) begin
            bad++;
            $display("FAIL result got=%h/%b want=%h/%b",
                     dout, sat, e.d, e.s);
          end
        end
      end
    end
  end

  task automatic expect_res(input logic [15:0] d,
                            input logic s);
    exp_t e;
    e.d = d;
    e.s = s;
    eq.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b);
    bit ok;
    ok = 0;
    inst = op;
    da = a;
    db = b;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL issue_timeout got=0 want=1");
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60 && eq.size() != 0; n++)
      @(posedge clk);
    #2;
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL drain_%s got=%0d want=0",
               tag, eq.size());
      eq.delete();
    end
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  initial begin
    vt[0]  = '{4'd2,  16'h0600, 16'h0A00, 16'h0F00, 1'b0};
    vt[1]  = '{4'd2,  16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
    vt[2]  = '{4'd0,  16'h7C00, 16'h0800, 16'h7FFF, 1'b1};
    vt[3]  = '{4'd1,  16'h8000, 16'h0001, 16'h8000, 1'b1};
    vt[4]  = '{4'd0,  16'h0400, 16'hFC00, 16'h0000, 1'b0};
    vt[5]  = '{4'd1,  16'h0400, 16'h0C00, 16'hF800, 1'b0};
    vt[6]  = '{4'd2,  16'hFC00, 16'h0600, 16'hFA00, 1'b0};
    vt[7]  = '{4'd2,  16'h0001, 16'h0200, 16'h0001, 1'b0};
    vt[8]  = '{4'd2,  16'h8000, 16'h8000, 16'h7FFF, 1'b1};
    vt[9]  = '{4'd2,  16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    vt[10] = '{4'd6,  16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0};
    vt[11] = '{4'd7,  16'h8000, 16'h0004, 16'hF800, 1'b0};
    vt[12] = '{4'd8,  16'h0001, 16'h0000, 16'h000F, 1'b0};
    vt[13] = '{4'd8,  16'h0000, 16'h0000, 16'h0010, 1'b0};
    vt[14] = '{4'd9,  16'hFFFF, 16'h0001, 16'h0001, 1'b0};
    vt[15] = '{4'd10, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0};
    vt[16] = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    inst = '0;
    da = '0;
    db = '0;

    #12;
    chk("rst_valid", {15'd0, out_valid}, 16'h0000);
    chk("rst_data", dout, 16'h0000);
    chk("rst_sat", {15'd0, sat}, 16'h0000);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {15'd0, in_ready}, 16'h0001);
    @(posedge clk);
    #1;

    // stateless ops, streamed back to back
    foreach (vt[i]) begin
      expect_res(vt[i].d, vt[i].s);
      issue(vt[i].op, vt[i].a, vt[i].b);
    end
    drain("vec");

    // 40 ACC to idx 3 of +4.0
    for (int k = 1; k <= 40; k++) begin
      if (k <= 7) expect_res(16'(k * 16'h1000), 1'b0);
      else        expect_res(16'h7FFF, 1'b1);
      issue(4'd3, 16'h0003, 16'h1000);
    end
    expect_res(16'h7FFF, 1'b1);
    issue(4'd5, 16'h0003, 16'h0000);
    expect_res(16'h0001, 1'b0);
    issue(4'd3, 16'h0003, 16'h0001);
    drain("acc");

    // backpressure stream of XORs
    bp_en = 1;
    for (int k = 0; k < 8; k++) begin
      expect_res(16'(k * 16'h1111) ^ 16'h00FF, 1'b0);
      issue(4'd6, 16'(k * 16'h1111), 16'h00FF);
    end
    drain("bp");
    bp_en = 0;
    @(posedge clk);
    #1;

    // MAC on idx 0 (from B), product 0.5*2.5
    expect_res(16'h0500, 1'b0);
    issue(4'd4, 16'h0200, 16'h0A00);
    expect_res(16'h0A00, 1'b0);
    issue(4'd4, 16'h0200, 16'h0A00);
    expect_res(16'h0A00, 1'b0);
    issue(4'd5, 16'h0000, 16'h0000);
    drain("mac");

    // reset with two instructions in flight
    issue(4'd3, 16'h0005, 16'h0100);
    issue(4'd0, 16'h0001, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {15'd0, out_valid}, 16'h0000);
    chk("midrst_data", dout, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("post_ready", {15'd0, in_ready}, 16'h0001);
    chk("post_valid", {15'd0, out_valid}, 16'h0000);
    @(posedge clk);
    #1;
    expect_res(16'h0000, 1'b0);
    issue(4'd3, 16'h0005, 16'h0000);
    expect_res(16'h0000, 1'b0);
    issue(4'd3, 16'h0003, 16'h0000);
    drain("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
